// File: rtl/clb_cfg_emitter.sv
// Serializes one CLB configuration frame onto an AXI-stream master: per-input type and index, then the LUT truth table.
// Define CLB_CFG_EMITTER_TLAST_EN to raise tlast on the final truth-table beat; otherwise tlast stays 0.
module clb_cfg_emitter #(
    parameter int LUT_WIDTH            = 4,
    parameter int BITSTREAM_DATA_WIDTH = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [2*LUT_WIDTH-1:0]          cfg_input_types,
    input  logic [8*LUT_WIDTH-1:0]          cfg_input_indices,
    input  logic [2**LUT_WIDTH-1:0]         cfg_lut_table,
    output logic                            cfg_bitstream_tvalid,
    output logic [BITSTREAM_DATA_WIDTH-1:0] cfg_bitstream_tdata,
    output logic                            cfg_bitstream_tlast,
    input  logic                            cfg_bitstream_tready,
    output logic                            busy,
    output logic                            done
);

    localparam int LUT_BITS = 2**LUT_WIDTH;
    localparam int IN_W     = (LUT_WIDTH > 1) ? $clog2(LUT_WIDTH) : 1;
    localparam int BIT_W    = (LUT_WIDTH > 3) ? LUT_WIDTH : 3;

    localparam logic [IN_W-1:0]  LAST_IN      = IN_W'(LUT_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_LUT_BIT = BIT_W'(LUT_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_TYPE    = BIT_W'(1);
    localparam logic [BIT_W-1:0] LAST_INDEX   = BIT_W'(7);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SEND_TYPE  = 2'd1;
    localparam logic [1:0] SEND_INDEX = 2'd2;
    localparam logic [1:0] SEND_LUT   = 2'd3;

    logic [1:0]                      state_reg, state_next;
    logic [IN_W-1:0]                 in_idx_reg, in_idx_next;
    logic [BIT_W-1:0]                bit_idx_reg, bit_idx_next;
    logic [2*LUT_WIDTH-1:0]          types_reg;
    logic [8*LUT_WIDTH-1:0]          indices_reg;
    logic [LUT_BITS-1:0]             lut_reg;
    logic                            tvalid_reg, busy_reg, done_reg, tlast_reg;
    logic [BITSTREAM_DATA_WIDTH-1:0] tdata_reg, tdata_next;
    logic                            load, finish, beat_bit, tlast_next, xfer;

    logic [1:0] type_arr [LUT_WIDTH];
    logic [7:0] idx_arr  [LUT_WIDTH];

    generate
        for (genvar gi = 0; gi < LUT_WIDTH; gi++) begin : g_unpack
            assign type_arr[gi] = types_reg[2*gi +: 2];
            assign idx_arr[gi]  = indices_reg[8*gi +: 8];
        end
    endgenerate

    assign xfer = tvalid_reg && cfg_bitstream_tready;

    // Next-state logic describes the beat that will be presented next cycle,
    // so the data/tlast registers are loaded with that beat one edge early.
    always_comb begin
        state_next   = state_reg;
        in_idx_next  = in_idx_reg;
        bit_idx_next = bit_idx_reg;
        load         = 1'b0;
        finish       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = SEND_TYPE;
                    in_idx_next  = '0;
                    bit_idx_next = '0;
                    load         = 1'b1;
                end
            end
            SEND_TYPE: begin
                if (xfer) begin
                    if (bit_idx_reg == LAST_TYPE) begin
                        bit_idx_next = '0;
                        state_next   = SEND_INDEX;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            SEND_INDEX: begin
                if (xfer) begin
                    if (bit_idx_reg == LAST_INDEX) begin
                        bit_idx_next = '0;
                        if (in_idx_reg == LAST_IN) begin
                            state_next = SEND_LUT;
                        end else begin
                            in_idx_next = in_idx_reg + 1'b1;
                            state_next  = SEND_TYPE;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                if (xfer) begin
                    if (bit_idx_reg == LAST_LUT_BIT) begin
                        bit_idx_next = '0;
                        state_next   = IDLE;
                        finish       = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        beat_bit = 1'b0;
        if (load) begin
            // Shadow registers are not yet loaded; beat 0 comes straight from the bus.
            beat_bit = cfg_input_types[0];
        end else begin
            case (state_next)
                SEND_TYPE:  beat_bit = type_arr[in_idx_next][bit_idx_next[0]];
                SEND_INDEX: beat_bit = idx_arr[in_idx_next][bit_idx_next[2:0]];
                SEND_LUT:   beat_bit = lut_reg[bit_idx_next[LUT_WIDTH-1:0]];
                default:    beat_bit = 1'b0;
            endcase
        end
        tdata_next    = '0;
        tdata_next[0] = beat_bit;
`ifdef CLB_CFG_EMITTER_TLAST_EN
        tlast_next = (state_next == SEND_LUT) && (bit_idx_next == LAST_LUT_BIT);
`else
        tlast_next = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            in_idx_reg  <= '0;
            bit_idx_reg <= '0;
            types_reg   <= '0;
            indices_reg <= '0;
            lut_reg     <= '0;
            tvalid_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            tdata_reg   <= '0;
            tlast_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            in_idx_reg  <= in_idx_next;
            bit_idx_reg <= bit_idx_next;
            if (load) begin
                types_reg   <= cfg_input_types;
                indices_reg <= cfg_input_indices;
                lut_reg     <= cfg_lut_table;
            end
            tvalid_reg <= (state_next != IDLE);
            busy_reg   <= (state_next != IDLE);
            done_reg   <= finish;
            tdata_reg  <= tdata_next;
            tlast_reg  <= tlast_next;
        end
    end

    assign cfg_bitstream_tvalid = tvalid_reg;
    assign cfg_bitstream_tdata  = tdata_reg;
    assign cfg_bitstream_tlast  = tlast_reg;
    assign busy                 = busy_reg;
    assign done                 = done_reg;

endmodule

// File: tb/tb_clb_cfg_emitter.sv
// Directed bench for clb_cfg_emitter (LUT_WIDTH=4): frame content, timing, backpressure, restart/reset behaviour.
module tb_clb_cfg_emitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_input_types;
    logic [31:0] cfg_input_indices;
    logic [15:0] cfg_lut_table;
    logic        tvalid;
    logic [0:0]  tdata;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clb_cfg_emitter #(.LUT_WIDTH(4), .BITSTREAM_DATA_WIDTH(1)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .cfg_input_types      (cfg_input_types),
        .cfg_input_indices    (cfg_input_indices),
        .cfg_lut_table        (cfg_lut_table),
        .cfg_bitstream_tvalid (tvalid),
        .cfg_bitstream_tdata  (tdata),
        .cfg_bitstream_tlast  (tlast),
        .cfg_bitstream_tready (tready),
        .busy                 (busy),
        .done                 (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference serialization: per input type(2) then index(8), then table(16), each LSB first.
    function automatic logic [55:0] model(input logic [7:0] t, input logic [31:0] ix, input logic [15:0] lut);
        logic [55:0] f;
        int pos;
        f   = '0;
        pos = 0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 2; b++) begin f[pos] = t[2*i+b];  pos++; end
            for (int b = 0; b < 8; b++) begin f[pos] = ix[8*i+b]; pos++; end
        end
        for (int b = 0; b < 16; b++) begin f[pos] = lut[b]; pos++; end
        return f;
    endfunction

    task automatic set_cfg(input logic [7:0] t, input logic [31:0] ix, input logic [15:0] lut);
        cfg_input_types   = t;
        cfg_input_indices = ix;
        cfg_lut_table     = lut;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle N+1 after start was sampled. Returns at the done cycle
    // (or right after a planted reset). chg_at/rst_at: beat at which to disturb, -1 for none.
    task automatic collect(input string name, input bit rnd, input int chg_at, input int rst_at,
                           output logic [55:0] bits, output int beats);
        int   cyc;
        int   last_x;
        bit   fin;
        bit   prev_stall;
        logic pd;
        logic pl;
        cyc = 0; last_x = 0; fin = 0; prev_stall = 0; pd = 0; pl = 0;
        bits = '0;
        beats = 0;
        while (!fin && cyc < 2000) begin
            cyc++;
            if (cyc == 1) check({name, " beat0_valid"}, 64'(tvalid), 64'd1);
            if (done) begin
                check({name, " done_busy"}, 64'(busy), 64'd0);
                check({name, " done_tvalid"}, 64'(tvalid), 64'd0);
                check({name, " done_after_last"}, 64'(cyc - last_x), 64'd1);
                check({name, " beat_count"}, 64'(beats), 64'd56);
                if (!rnd) check({name, " done_cycle"}, 64'(cyc), 64'd57);
                fin = 1;
            end else begin
                check({name, " tvalid_held"}, 64'(tvalid), 64'd1);
                if (prev_stall) begin
                    check({name, " stall_tdata"}, 64'(tdata[0]), 64'(pd));
                    check({name, " stall_tlast"}, 64'(tlast), 64'(pl));
                end
                if (beats == rst_at) begin
                    rst_n  = 1'b0;
                    tready = 1'b1;
                    @(negedge clk);
                    check({name, " rst_tvalid"}, 64'(tvalid), 64'd0);
                    check({name, " rst_busy"}, 64'(busy), 64'd0);
                    check({name, " rst_tlast"}, 64'(tlast), 64'd0);
                    rst_n = 1'b1;
                    fin   = 1;
                end else begin
                    if (beats == chg_at) begin
                        start = 1'b1;
                        set_cfg(8'h15, 32'hAAAA_AAAA, 16'h0F0F);
                    end else begin
                        start = 1'b0;
                    end
                    tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (tready) begin
                        if (beats < 56) bits[beats] = tdata[0];
`ifdef CLB_CFG_EMITTER_TLAST_EN
                        check({name, " tlast"}, 64'(tlast), 64'(beats == 55));
`else
                        check({name, " tlast"}, 64'(tlast), 64'd0);
`endif
                        beats++;
                        last_x     = cyc;
                        prev_stall = 0;
                    end else begin
                        prev_stall = 1;
                        pd         = tdata[0];
                        pl         = tlast;
                    end
                    @(negedge clk);
                end
            end
        end
        start = 1'b0;
        if (!fin) check({name, " timeout"}, 64'd0, 64'd1);
    endtask

    localparam logic [7:0]  TA = 8'h24;          // types {0,1,2,0}
    localparam logic [31:0] IA = 32'h0700_0503;  // indices {3,5,0,7}
    localparam logic [15:0] LA = 16'hE8A1;
    localparam logic [7:0]  TB = 8'h1A;
    localparam logic [31:0] IB = 32'hC381_FF42;
    localparam logic [15:0] LB = 16'h1234;
    localparam logic [7:0]  TC = 8'h09;
    localparam logic [31:0] IC = 32'h1122_3344;
    localparam logic [15:0] LC = 16'hBEEF;

    initial begin
        logic [55:0] got;
        logic [55:0] got2;
        int          n;
        void'($urandom(32'd1234));
        rst_n  = 1'b0;
        start  = 1'b0;
        tready = 1'b0;
        set_cfg(TA, IA, LA);
        repeat (3) @(negedge clk);
        check("reset tvalid", 64'(tvalid), 64'd0);
        check("reset tdata", 64'(tdata), 64'd0);
        check("reset tlast", 64'(tlast), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame against hand-derived beats and the reference model
        pulse_start();
        collect("basic", 0, -1, -1, got, n);
        check("basic beats0_11", 64'(got[11:0]), 64'h40C);
        check("basic beats40_55", 64'(got[55:40]), 64'hE8A1);
        check("basic frame", 64'(got), 64'(model(TA, IA, LA)));
        $display("frame basic: %0d beats, bits=0x%014h", n, got);
        repeat (2) @(negedge clk);

        // Random backpressure
        pulse_start();
        collect("stall", 1, -1, -1, got, n);
        check("stall frame", 64'(got), 64'(model(TA, IA, LA)));
        $display("frame stall: %0d beats, bits=0x%014h", n, got);
        tready = 1'b1;
        repeat (2) @(negedge clk);

        // start + cfg change mid-frame are ignored
        set_cfg(TA, IA, LA);
        pulse_start();
        collect("ignore", 0, 10, -1, got, n);
        check("ignore frame", 64'(got), 64'(model(TA, IA, LA)));
        $display("frame ignore: %0d beats, bits=0x%014h", n, got);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ignore no_second_tvalid", 64'(tvalid), 64'd0);
            check("ignore no_second_busy", 64'(busy), 64'd0);
        end

        // Reset at beat 20, then a fresh frame from beat 0
        set_cfg(TB, IB, LB);
        pulse_start();
        collect("abort", 0, -1, 20, got, n);
        $display("frame abort: reset after %0d beats", n);
        @(negedge clk);
        check("abort idle_tvalid", 64'(tvalid), 64'd0);
        pulse_start();
        collect("after_rst", 0, -1, -1, got, n);
        check("after_rst type0", 64'(got[1:0]), 64'(TB[1:0]));
        check("after_rst frame", 64'(got), 64'(model(TB, IB, LB)));
        $display("frame after_rst: %0d beats, bits=0x%014h", n, got);
        @(negedge clk);

        // Reset wins over start in the same cycle
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("rst_prio tvalid", 64'(tvalid), 64'd0);
        check("rst_prio busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst_prio no_queue", 64'(tvalid), 64'd0);
        $display("reset priority: tvalid=%0d busy=%0d", tvalid, busy);

        // Back-to-back frames, start in the done cycle
        set_cfg(TA, IA, LA);
        pulse_start();
        collect("b2b_first", 0, -1, -1, got, n);
        set_cfg(TC, IC, LC);
        pulse_start();
        collect("b2b_second", 0, -1, -1, got2, n);
        check("b2b first_frame", 64'(got), 64'(model(TA, IA, LA)));
        check("b2b second_frame", 64'(got2), 64'(model(TC, IC, LC)));
        $display("frames b2b: 0x%014h then 0x%014h", got, got2);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clb_cfg_emitter.md
# clb_cfg_emitter

Configuration-bitstream transmitter for one CLB. It accepts a parallel CLB configuration: per-LUT-input source type, per-LUT-input source index and LUT truth table. It serializes that configuration onto an AXI-stream master in exactly the field order and widths a CLB's configuration port consumes. It sits between the fabric configuration controller and the `cfg_bitstream` slave port of a CLB, and also serves as the stimulus generator for CLB benches.

## Interface
Parameters:
- `LUT_WIDTH`, default 4: number of LUT inputs. Supported range is 2..6.
- `BITSTREAM_DATA_WIDTH`, default 1: width of `tdata`. Only bit 0 carries configuration; the upper bits are driven 0.

Ports (clock, reset, control and outputs):
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request to send one configuration frame. Sampled only in IDLE.
- `cfg_input_types`  in  2*LUT_WIDTH  2-bit type for input i, in bits [2i+1:2i]. Encoding: 0 = neighbour, 1 = io, 2 = feedback.
- `cfg_input_indices`  in  8*LUT_WIDTH  8-bit source index for input i, in bits [8i+7:8i].
- `cfg_lut_table`  in  2**LUT_WIDTH  truth table; bit k is the output for input vector k.
- `cfg_bitstream`  axi_stream_if.master  `BITSTREAM_DATA_WIDTH`  serialized frame (`tvalid`/`tdata`/`tlast` out, `tready` in).
- `busy`  out  1  high while a frame is in flight.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, SEND_TYPE, SEND_INDEX, SEND_LUT.
- IDLE, `start`=1:
  - capture all three `cfg_*` buses into shadow registers.
  - clear the input iterator `in_idx` and the bit counter `bit_idx`.
  - go to SEND_TYPE.
- Inputs are used only at capture. Changes during a frame have no effect.
- `start` outside IDLE is ignored, not queued.
- Frame order: for in_idx = 0..LUT_WIDTH-1, send type (2 bits) then index (8 bits). After all inputs, send the truth table (2**LUT_WIDTH bits).
- Every field is sent LSB first, one bit per beat on `tdata[0]`.
- A beat transfers when `tvalid && tready`. The counters advance only on a transfer.
- SEND_TYPE: on a transfer with bit_idx==1, clear bit_idx and go to SEND_INDEX.
- SEND_INDEX: on a transfer with bit_idx==7:
  - clear bit_idx.
  - if in_idx==LUT_WIDTH-1, go to SEND_LUT.
  - otherwise increment in_idx and go to SEND_TYPE.
- SEND_LUT: on a transfer with bit_idx==2**LUT_WIDTH-1, go to IDLE and pulse `done`.
- Frame length: 10*LUT_WIDTH + 2**LUT_WIDTH beats (56 for LUT_WIDTH=4).
- Counter widths:
  - in_idx: $clog2(LUT_WIDTH).
  - bit_idx: max(3, LUT_WIDTH) bits.
  - No counter wraps; each is cleared explicitly at a field boundary.
- AXI rules:
  - `tvalid` is high in every non-IDLE state.
  - `tvalid` never drops before its beat transfers.
  - `tdata`/`tlast` are held stable while `tvalid && !tready`.

## Timing
- All outputs are registered.
- Reset values: `tvalid`=0, `tdata`=0, `tlast`=0, `busy`=0, `done`=0, state IDLE, all shadow registers and counters 0.
- `start` sampled at edge N gives `tvalid`=1, `busy`=1 and beat 0 on `tdata` in cycle N+1.
- With `tready` held 1, beats occupy cycles N+1..N+F, where F is the frame length.
- In cycle N+F+1: `done`=1, `busy`=0, `tvalid`=0, state IDLE.
- A `start` in the `done` cycle is accepted, so back-to-back frames have exactly one idle cycle between them.
- Backpressure adds exactly one cycle per cycle of `tready`=0. The bit sequence is unchanged.
- `rst_n` low mid-frame: at the next edge, `tvalid`/`busy`/`done`/`tlast` go to 0 and state returns to IDLE. The partial frame is abandoned and is not resumed.
- Reset takes priority over `start` in the same cycle.

## Configuration
- Macro `CLB_CFG_EMITTER_TLAST_EN`.
- Defined: `tlast`=1 on the final truth-table beat only (beat F-1), and 0 on every other beat.
- Undefined: `tlast` is tied 0 for the whole frame. Use this for consumers that must not see a `tlast` inside a multi-CLB chain.

## Test plan
- Basic frame, LUT_WIDTH=4, types {0,1,2,0}, indices {3,5,0,7}, table 16'hE8A1, `tready`=1:
  - 56 beats; beats 0-11 = 0,0, 1,1,0,0,0,0,0,0, 1,0.
  - Beats 40-55 = 1,0,0,0,0,1,0,1,0,0,0,1,0,1,1,1.
  - `done` at cycle 57 after `start`.
- Same frame with pseudo-random `tready` (50%):
  - identical bit sequence.
  - `tdata` and `tvalid` stable on every stalled cycle.
  - `done` exactly one cycle after the last transfer.
- `start` pulsed at beat 10, and all `cfg_*` inputs changed at beat 10:
  - output sequence still matches the captured values.
  - no second frame follows.
- `rst_n` low for one cycle at beat 20:
  - `tvalid`=0 and `busy`=0 the next cycle.
  - a subsequent `start` restarts from beat 0 with type[0].
- With `CLB_CFG_EMITTER_TLAST_EN`: `tlast` high only on beat 55. Without it: `tlast` is 0 on all 56 beats.
- Two frames back-to-back, with `start` asserted in the `done` cycle:
  - the second frame's beat 0 appears in the next cycle.
  - the second frame carries its own captured values.
